// File: rtl/line_writeback_buffer_if.sv
// AXI3 write-channel bundle between the write-back buffer (master) and memory (slave).
interface line_writeback_buffer_if #(
    parameter int BUS_WIDTH  = 4,
    parameter int DATA_WIDTH = 32
);
    logic [BUS_WIDTH-1:0]    awid;
    logic [31:0]             awaddr;
    logic [3:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [BUS_WIDTH-1:0]    wid;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [BUS_WIDTH-1:0]    bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/line_writeback_buffer.sv
// Single-entry write-back buffer: holds one evicted line and writes it out as one
// AXI3 INCR burst, with a combinational lookup so the cache can forward the pending line.
module line_writeback_buffer #(
    parameter  int LINE_WIDTH  = 256,
    parameter  int DATA_WIDTH  = 32,
    parameter  int BUS_WIDTH   = 4,
    parameter  int AWID        = 3,
    localparam int OFFSET      = $clog2(LINE_WIDTH / 8),
    localparam int LABEL_WIDTH = 32 - OFFSET
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [LABEL_WIDTH-1:0]   label_i,
    input  logic [LINE_WIDTH-1:0]    data_i,
    output logic                     ready,
    input  logic [LABEL_WIDTH-1:0]   query_label,
    output logic                     query_hit,
    output logic [LINE_WIDTH-1:0]    query_data,
    output logic                     done,
    output logic                     err,
    line_writeback_buffer_if.master  axi
);
    localparam int N     = LINE_WIDTH / DATA_WIDTH;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic [LABEL_WIDTH-1:0] label_q, label_d;
    logic [LINE_WIDTH-1:0]  line_q, line_d;

    logic [N-1:0][DATA_WIDTH-1:0] line_words;
    logic                         unused_bid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        label_d = label_q;
        line_d  = line_q;
        case (state_q)
            S_IDLE: begin
                if (push) begin
                    label_d = label_i;
                    line_d  = data_i;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (axi.awready) state_d = S_DATA;
            end
            S_DATA: begin
                if (axi.wready) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = S_RESP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (axi.bvalid) begin
                    state_d = S_IDLE;
                    if (axi.bresp != 2'b00) err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line storage is not reset: leaving IDLE is the only thing that makes it visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
        label_q <= label_d;
        line_q  <= line_d;
    end

    assign line_words = line_q;

    assign ready      = (state_q == S_IDLE);
    assign query_hit  = (state_q != S_IDLE) && (label_q == query_label);
    assign query_data = line_q;
    assign done       = (state_q == S_RESP) && axi.bvalid;
    assign err        = err_q;

    // AW fields are constant apart from the latched label, so they stay stable under stall.
    assign axi.awid    = BUS_WIDTH'(AWID);
    assign axi.awaddr  = {label_q, {OFFSET{1'b0}}};
    assign axi.awlen   = 4'(N - 1);
    assign axi.awsize  = 3'($clog2(DATA_WIDTH / 8));
    assign axi.awburst = 2'b01;
    assign axi.awvalid = (state_q == S_ADDR);

    assign axi.wid     = BUS_WIDTH'(AWID);
    assign axi.wdata   = line_words[cnt_q];
    assign axi.wstrb   = '1;
    assign axi.wlast   = (state_q == S_DATA) && (cnt_q == LAST_BEAT);
    assign axi.wvalid  = (state_q == S_DATA);

    assign axi.bready  = (state_q == S_RESP);

    assign unused_bid  = ^axi.bid;
endmodule

// File: tb/tb_line_writeback_buffer.sv
// Directed bench for line_writeback_buffer: memory-side slave model plus one task per scenario.
module tb_line_writeback_buffer;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic [26:0]   label_i = '0;
    logic [255:0]  data_i = '0;
    logic          ready;
    logic [26:0]   query_label = '0;
    logic          query_hit;
    logic [255:0]  query_data;
    logic          done;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // slave-side drive variables
    logic       stall = 1'b0;
    logic [1:0] bresp_val = 2'b00;
    logic       wtog = 1'b0;
    logic       bpend = 1'b0;
    logic       wready_s = 1'b1;
    logic       bvalid_s = 1'b0;
    logic [1:0] bresp_s = 2'b00;

    // monitor state
    int          aw_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] last_awaddr = '0;
    logic [31:0] beat_q[$];
    int          last_pos[$];

    line_writeback_buffer_if #(.BUS_WIDTH(4), .DATA_WIDTH(32)) axi ();

    line_writeback_buffer #(
        .LINE_WIDTH(256),
        .DATA_WIDTH(32),
        .BUS_WIDTH(4),
        .AWID(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .push(push),
        .label_i(label_i),
        .data_i(data_i),
        .ready(ready),
        .query_label(query_label),
        .query_hit(query_hit),
        .query_data(query_data),
        .done(done),
        .err(err),
        .axi(axi)
    );

    assign axi.awready = 1'b1;
    assign axi.wready  = wready_s;
    assign axi.bvalid  = bvalid_s;
    assign axi.bresp   = bresp_s;
    assign axi.bid     = 4'd3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Slave + monitor: sample at negedge, update slave inputs #1 after the next posedge.
    always begin : slave
        logic s_w, s_last, s_b, s_wv, s_rst;
        @(negedge clk);
        s_w    = axi.wvalid && axi.wready;
        s_last = s_w && axi.wlast;
        s_b    = axi.bvalid && axi.bready;
        s_wv   = axi.wvalid;
        s_rst  = rst;
        if (axi.awvalid && axi.awready) begin
            aw_cnt      = aw_cnt + 1;
            last_awaddr = axi.awaddr;
        end
        if (s_w) begin
            beat_q.push_back(axi.wdata);
            if (axi.wlast) last_pos.push_back(beat_q.size());
        end
        if (done) done_cnt = done_cnt + 1;
        @(posedge clk);
        #1;
        wtog = (s_wv === 1'b1 && !s_rst) ? ~wtog : 1'b0;
        if (s_rst)       bpend = 1'b0;
        else if (s_last) bpend = 1'b1;
        else if (s_b)    bpend = 1'b0;
        wready_s = stall ? wtog : 1'b1;
        bvalid_s = bpend;
        bresp_s  = bresp_val;
    end

    function automatic logic [255:0] make_line(input logic [31:0] base, input logic [31:0] step);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + step * k;
        return l;
    endfunction

    function automatic logic [31:0] word_of(input logic [255:0] l, input int k);
        return l[k*32 +: 32];
    endfunction

    task automatic clear_mon();
        beat_q.delete();
        last_pos.delete();
        aw_cnt   = 0;
        done_cnt = 0;
    endtask

    // Called #1 after a posedge; the push is sampled on the following edge.
    task automatic do_push(input logic [26:0] l, input logic [255:0] d, output int pc);
        push = 1'b1; label_i = l; data_i = d; pc = cyc;
        @(posedge clk); #1;
        push = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        repeat (bound) begin
            @(negedge clk);
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1)      begin n_bad++; $display("FAIL reset_ready got %b want 1", ready); end
        n_cmp++; if (axi.awvalid !== 1'b0) begin n_bad++; $display("FAIL reset_awvalid got %b want 0", axi.awvalid); end
        n_cmp++; if (axi.wvalid !== 1'b0 || axi.wlast !== 1'b0) begin n_bad++; $display("FAIL reset_w got wvalid=%b wlast=%b want 0/0", axi.wvalid, axi.wlast); end
        n_cmp++; if (axi.bready !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL reset_b got bready=%b done=%b want 0/0", axi.bready, done); end
        n_cmp++; if (query_hit !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_hit_err got hit=%b err=%b want 0/0", query_hit, err); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [255:0] line;
        int pc;
        bit ok;
        line = make_line(32'h0, 32'h11111111);
        clear_mon();
        query_label = 27'h10;
        @(posedge clk); #1;
        do_push(27'h10, line, pc);
        @(negedge clk);  // ADDR
        n_cmp++; if (axi.awvalid !== 1'b1 || axi.awaddr !== 32'h00000200) begin n_bad++; $display("FAIL basic_aw got awvalid=%b awaddr=%h want 1/00000200", axi.awvalid, axi.awaddr); end
        n_cmp++; if (axi.awlen !== 4'd7 || axi.awsize !== 3'd2 || axi.awburst !== 2'b01 || axi.awid !== 4'd3) begin n_bad++; $display("FAIL basic_awfields got len=%0d size=%0d burst=%0d id=%0d want 7/2/1/3", axi.awlen, axi.awsize, axi.awburst, axi.awid); end
        n_cmp++; if (axi.wvalid !== 1'b0 || ready !== 1'b0) begin n_bad++; $display("FAIL basic_addr_phase got wvalid=%b ready=%b want 0/0", axi.wvalid, ready); end
        n_cmp++; if (query_hit !== 1'b1 || query_data !== line) begin n_bad++; $display("FAIL basic_query_addr got hit=%b data=%h want 1/%h", query_hit, query_data, line); end
        @(negedge clk);  // first DATA beat
        n_cmp++; if (axi.wvalid !== 1'b1 || axi.wstrb !== 4'hF || axi.wid !== 4'd3) begin n_bad++; $display("FAIL basic_wfields got wvalid=%b wstrb=%h wid=%0d want 1/f/3", axi.wvalid, axi.wstrb, axi.wid); end
        query_label = 27'h11; #1;
        n_cmp++; if (query_hit !== 1'b0) begin n_bad++; $display("FAIL basic_query_miss got %b want 0", query_hit); end
        query_label = 27'h10; #1;
        n_cmp++; if (query_hit !== 1'b1 || query_data !== line) begin n_bad++; $display("FAIL basic_query_data got hit=%b data=%h want 1/%h", query_hit, query_data, line); end
        wait_done(40, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_done_timeout got none want done within 40 cycles"); end
        // counting the push cycle as cycle 1, done lands in cycle 11
        n_cmp++; if (cyc - pc !== 10) begin n_bad++; $display("FAIL basic_latency got %0d want 10", cyc - pc); end
        n_cmp++; if (query_hit !== 1'b1) begin n_bad++; $display("FAIL basic_hit_at_done got %b want 1", query_hit); end
        n_cmp++; if (beat_q.size() !== 8) begin n_bad++; $display("FAIL basic_beats got %0d want 8", beat_q.size()); end
        for (int k = 0; k < 8 && k < beat_q.size(); k++) begin
            n_cmp++; if (beat_q[k] !== word_of(line, k)) begin n_bad++; $display("FAIL basic_beat%0d got %h want %h", k, beat_q[k], word_of(line, k)); end
        end
        n_cmp++; if (last_pos.size() !== 1 || (last_pos.size() > 0 && last_pos[0] !== 8)) begin n_bad++; $display("FAIL basic_wlast got count=%0d want single wlast on beat 8", last_pos.size()); end
        n_cmp++; if (aw_cnt !== 1) begin n_bad++; $display("FAIL basic_aw_count got %0d want 1", aw_cnt); end
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1 || done !== 1'b0 || query_hit !== 1'b0) begin n_bad++; $display("FAIL basic_after_done got ready=%b done=%b hit=%b want 1/0/0", ready, done, query_hit); end
        n_cmp++; if (done_cnt !== 1 || err !== 1'b0) begin n_bad++; $display("FAIL basic_done_count got done=%0d err=%b want 1/0", done_cnt, err); end
    endtask

    task automatic test_stall();
        logic [255:0] line;
        int pc;
        bit ok;
        line = make_line(32'hA0000000, 32'h01010101);
        clear_mon();
        stall = 1'b1;
        query_label = 27'h33;
        @(posedge clk); #1;
        do_push(27'h33, line, pc);
        @(negedge clk);  // ADDR
        @(negedge clk);  // DATA, wready low
        n_cmp++; if (axi.wready !== 1'b0 || axi.wdata !== word_of(line, 0)) begin n_bad++; $display("FAIL stall_first got wready=%b wdata=%h want 0/%h", axi.wready, axi.wdata, word_of(line, 0)); end
        @(negedge clk);  // wready high, same word
        n_cmp++; if (axi.wready !== 1'b1 || axi.wdata !== word_of(line, 0)) begin n_bad++; $display("FAIL stall_held got wready=%b wdata=%h want 1/%h", axi.wready, axi.wdata, word_of(line, 0)); end
        @(negedge clk);
        n_cmp++; if (axi.wdata !== word_of(line, 1)) begin n_bad++; $display("FAIL stall_advance got %h want %h", axi.wdata, word_of(line, 1)); end
        wait_done(60, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_done_timeout got none want done within 60 cycles"); end
        n_cmp++; if (cyc - pc !== 18) begin n_bad++; $display("FAIL stall_latency got %0d want 18", cyc - pc); end
        n_cmp++; if (beat_q.size() !== 8) begin n_bad++; $display("FAIL stall_beats got %0d want 8", beat_q.size()); end
        for (int k = 0; k < 8 && k < beat_q.size(); k++) begin
            n_cmp++; if (beat_q[k] !== word_of(line, k)) begin n_bad++; $display("FAIL stall_beat%0d got %h want %h", k, beat_q[k], word_of(line, k)); end
        end
        stall = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [255:0] line, line2;
        int pc, pc2;
        bit ok;
        line  = make_line(32'h00000100, 32'h1);
        line2 = make_line(32'hCAFE0000, 32'h10);
        clear_mon();
        query_label = 27'h10;
        @(posedge clk); #1;
        do_push(27'h10, line, pc);
        repeat (3) @(posedge clk);
        #1;
        push = 1'b1; label_i = 27'h5; data_i = line2;
        @(posedge clk); #1;
        push = 1'b0;
        @(negedge clk);
        n_cmp++; if (query_hit !== 1'b1 || query_data !== line) begin n_bad++; $display("FAIL b2b_latched got hit=%b data=%h want 1/%h", query_hit, query_data, line); end
        query_label = 27'h5; #1;
        n_cmp++; if (query_hit !== 1'b0) begin n_bad++; $display("FAIL b2b_ignored_label got hit=%b want 0", query_hit); end
        query_label = 27'h10;
        wait_done(40, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_done1_timeout got none want done"); end
        n_cmp++; if (aw_cnt !== 1 || last_awaddr !== 32'h00000200) begin n_bad++; $display("FAIL b2b_aw1 got count=%0d addr=%h want 1/00000200", aw_cnt, last_awaddr); end
        @(posedge clk); #1;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got %b want 1", ready); end
        beat_q.delete();
        last_pos.delete();
        query_label = 27'h5;
        do_push(27'h5, line2, pc2);
        @(negedge clk);
        n_cmp++; if (axi.awvalid !== 1'b1 || axi.awaddr !== 32'h000000A0) begin n_bad++; $display("FAIL b2b_aw2 got awvalid=%b addr=%h want 1/000000a0", axi.awvalid, axi.awaddr); end
        wait_done(40, ok);
        n_cmp++; if (!ok || cyc - pc2 !== 10) begin n_bad++; $display("FAIL b2b_done2 got ok=%0d latency=%0d want 1/10", ok, cyc - pc2); end
        n_cmp++; if (aw_cnt !== 2 || beat_q.size() !== 8) begin n_bad++; $display("FAIL b2b_counts got aw=%0d beats=%0d want 2/8", aw_cnt, beat_q.size()); end
        for (int k = 0; k < 8 && k < beat_q.size(); k++) begin
            n_cmp++; if (beat_q[k] !== word_of(line2, k)) begin n_bad++; $display("FAIL b2b_beat%0d got %h want %h", k, beat_q[k], word_of(line2, k)); end
        end
        @(negedge clk);
    endtask

    task automatic test_midburst_reset();
        logic [255:0] line, line3;
        int pc, seen, dcount;
        bit ok;
        line  = make_line(32'hDEAD0000, 32'h3);
        line3 = make_line(32'h55550000, 32'h100);
        clear_mon();
        query_label = 27'h77;
        @(posedge clk); #1;
        do_push(27'h77, line, pc);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (axi.wvalid === 1'b1 && axi.wready === 1'b1) seen++;
            if (seen == 3) break;
        end
        n_cmp++; if (seen !== 3) begin n_bad++; $display("FAIL rst_beats_timeout got %0d want 3", seen); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (axi.wvalid !== 1'b0 || ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid got wvalid=%b ready=%b want 0/1", axi.wvalid, ready); end
        n_cmp++; if (axi.awvalid !== 1'b0 || axi.bready !== 1'b0 || query_hit !== 1'b0) begin n_bad++; $display("FAIL rst_mid_misc got awvalid=%b bready=%b hit=%b want 0/0/0", axi.awvalid, axi.bready, query_hit); end
        dcount = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        n_cmp++; if (dcount !== 0) begin n_bad++; $display("FAIL rst_no_done got %0d pulses want 0", dcount); end
        beat_q.delete();
        last_pos.delete();
        query_label = 27'h12;
        @(posedge clk); #1;
        do_push(27'h12, line3, pc);
        wait_done(40, ok);
        n_cmp++; if (!ok || beat_q.size() !== 8) begin n_bad++; $display("FAIL rst_fresh got ok=%0d beats=%0d want 1/8", ok, beat_q.size()); end
        for (int k = 0; k < 8 && k < beat_q.size(); k++) begin
            n_cmp++; if (beat_q[k] !== word_of(line3, k)) begin n_bad++; $display("FAIL rst_fresh_beat%0d got %h want %h", k, beat_q[k], word_of(line3, k)); end
        end
        @(negedge clk);
    endtask

    task automatic test_error();
        logic [255:0] line;
        int pc;
        bit ok;
        line = make_line(32'h0F0F0000, 32'h7);
        bresp_val = 2'b10;
        query_label = 27'h40;
        @(posedge clk); #1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_initial got %b want 0", err); end
        do_push(27'h40, line, pc);
        wait_done(40, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL err_done_timeout got none want done"); end
        @(negedge clk);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set got %b want 1", err); end
        bresp_val = 2'b00;
        @(posedge clk); #1;
        do_push(27'h41, line, pc);
        wait_done(40, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL err_done2_timeout got none want done"); end
        @(negedge clk);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", err); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_cleared got %b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_midburst_reset();
        test_error();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want test completion");
        $fatal(1, "watchdog");
    end
endmodule
